// File: rtl/traffic_light_ctrl_timed.sv
// Two-road traffic light controller with programmable phase timers,
// latched pedestrian walk phase and maintenance flash mode.
module traffic_light_ctrl_timed #(
  parameter int MIN_GREEN_MAIN  = 8,
  parameter int Y_TIME          = 3,
  parameter int ALL_RED         = 2,
  parameter int MAX_GREEN_CNTRY = 10,
  parameter int WALK_TIME       = 6,
  parameter int FLASH_HALF      = 4,
  parameter int CNT_W           = 8
) (
  input  logic       CLOCK,
  input  logic       CLEAR,
  input  logic       CAR_ON_CNTRY_RD,
  input  logic       PED_REQ,
  input  logic       FLASH_MODE,
  output logic [1:0] MAIN_SIG,
  output logic [1:0] CNTRY_SIG,
  output logic       WALK,
  output logic [2:0] STATE
);

  // state  | meaning
  // S_MGRN | main green, country red
  // S_MYEL | main yellow
  // S_ARED1| all-red clearance before country/walk
  // S_CGRN | country green
  // S_CYEL | country yellow
  // S_ARED2| all-red clearance before main green
  // S_WALK | pedestrian walk, both heads red
  // S_FLASH| maintenance flash
  typedef enum logic [2:0] {
    S_MGRN  = 3'd0,
    S_MYEL  = 3'd1,
    S_ARED1 = 3'd2,
    S_CGRN  = 3'd3,
    S_CYEL  = 3'd4,
    S_ARED2 = 3'd5,
    S_WALK  = 3'd6,
    S_FLASH = 3'd7
  } state_t;

  localparam logic [1:0] RED = 2'd0;
  localparam logic [1:0] YEL = 2'd1;
  localparam logic [1:0] GRN = 2'd2;
  localparam logic [1:0] OFF = 2'd3;

  localparam logic [CNT_W-1:0] MG_LAST = CNT_W'(MIN_GREEN_MAIN - 1);
  localparam logic [CNT_W-1:0] Y_LAST  = CNT_W'(Y_TIME - 1);
  localparam logic [CNT_W-1:0] AR_LAST = CNT_W'(ALL_RED - 1);
  localparam logic [CNT_W-1:0] CG_LAST = CNT_W'(MAX_GREEN_CNTRY - 1);
  localparam logic [CNT_W-1:0] WK_LAST = CNT_W'(WALK_TIME - 1);
  localparam logic [CNT_W-1:0] FL_LAST = CNT_W'(FLASH_HALF - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             ped_pending, ped_nxt;
  logic             flash_phase, phase_nxt;
  logic [1:0]       main_nxt, cntry_nxt;
  logic             walk_nxt;

  always_comb begin
    state_nxt = state;
    if (FLASH_MODE && state != S_FLASH) begin
      state_nxt = S_FLASH;
    end else begin
      case (state)
        S_MGRN:  if (cnt >= MG_LAST && (CAR_ON_CNTRY_RD || ped_pending)) state_nxt = S_MYEL;
        S_MYEL:  if (cnt == Y_LAST)  state_nxt = S_ARED1;
        S_ARED1: if (cnt == AR_LAST) state_nxt = ped_pending ? S_WALK : S_CGRN;
        S_CGRN:  if (!CAR_ON_CNTRY_RD || cnt == CG_LAST) state_nxt = S_CYEL;
        S_CYEL:  if (cnt == Y_LAST)  state_nxt = S_ARED2;
        S_ARED2: if (cnt == AR_LAST) state_nxt = S_MGRN;
        S_WALK:  if (cnt == WK_LAST) state_nxt = S_MGRN;
        S_FLASH: if (!FLASH_MODE)    state_nxt = S_ARED2;
        default: state_nxt = S_MGRN;
      endcase
    end
  end

  // In flash the phase counter doubles as the half-period timer.
  always_comb begin
    cnt_nxt   = cnt;
    phase_nxt = flash_phase;
    if (state_nxt != state) begin
      cnt_nxt = '0;
      if (state_nxt == S_FLASH) phase_nxt = 1'b0;
    end else if (state == S_FLASH && cnt == FL_LAST) begin
      cnt_nxt   = '0;
      phase_nxt = ~flash_phase;
    end else if (cnt != '1) begin
      cnt_nxt = cnt + 1'b1;
    end
  end

  // Clear on walk entry wins over a same-cycle button press.
  always_comb begin
    ped_nxt = ped_pending;
    if (state_nxt == S_WALK && state != S_WALK) ped_nxt = 1'b0;
    else if (state != S_WALK && PED_REQ)        ped_nxt = 1'b1;
  end

  always_comb begin
    main_nxt  = RED;
    cntry_nxt = RED;
    walk_nxt  = 1'b0;
    case (state_nxt)
      S_MGRN:  main_nxt  = GRN;
      S_MYEL:  main_nxt  = YEL;
      S_CGRN:  cntry_nxt = GRN;
      S_CYEL:  cntry_nxt = YEL;
      S_WALK:  walk_nxt  = 1'b1;
      S_FLASH: begin
        main_nxt  = phase_nxt ? OFF : YEL;
        cntry_nxt = phase_nxt ? OFF : RED;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (CLEAR) begin
      state       <= S_MGRN;
      cnt         <= '0;
      ped_pending <= 1'b0;
      flash_phase <= 1'b0;
      MAIN_SIG    <= GRN;
      CNTRY_SIG   <= RED;
      WALK        <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      ped_pending <= ped_nxt;
      flash_phase <= phase_nxt;
      MAIN_SIG    <= main_nxt;
      CNTRY_SIG   <= cntry_nxt;
      WALK        <= walk_nxt;
    end
  end

  assign STATE = state;

endmodule

// File: tb/tb_traffic_light_ctrl_timed.sv
// Scoreboard bench for traffic_light_ctrl_timed: a phase/elapsed-time reference
// model queues the expected heads after every edge; a monitor compares them.
module tb_traffic_light_ctrl_timed;
  localparam int MG = 8, YT = 3, AR = 2, CG = 10, WT = 6, FH = 4;

  logic       CLOCK = 1'b0;
  logic       CLEAR = 1'b0;
  logic       CAR_ON_CNTRY_RD = 1'b0;
  logic       PED_REQ = 1'b0;
  logic       FLASH_MODE = 1'b0;
  logic [1:0] MAIN_SIG, CNTRY_SIG;
  logic       WALK;
  logic [2:0] STATE;

  traffic_light_ctrl_timed dut (
    .CLOCK(CLOCK), .CLEAR(CLEAR), .CAR_ON_CNTRY_RD(CAR_ON_CNTRY_RD),
    .PED_REQ(PED_REQ), .FLASH_MODE(FLASH_MODE), .MAIN_SIG(MAIN_SIG),
    .CNTRY_SIG(CNTRY_SIG), .WALK(WALK), .STATE(STATE)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {
    logic [1:0] main_sig;
    logic [1:0] cntry_sig;
    logic       walk;
    logic [2:0] state;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   stim_done = 0;

  // Reference model: phase number, cycles spent in it, pending walk request.
  int phase = 0;
  int elapsed = 0;
  bit ped = 0;

  function automatic void model_step(input bit clr, input bit car, input bit preq, input bit fl);
    int np;
    if (clr) begin
      phase = 0; elapsed = 0; ped = 0;
      return;
    end
    np = phase;
    if (fl && phase != 7) np = 7;
    else begin
      case (phase)
        0: if (elapsed >= MG - 1 && (car || ped)) np = 1;
        1: if (elapsed == YT - 1) np = 2;
        2: if (elapsed == AR - 1) np = ped ? 6 : 3;
        3: if (!car || elapsed == CG - 1) np = 4;
        4: if (elapsed == YT - 1) np = 5;
        5: if (elapsed == AR - 1) np = 0;
        6: if (elapsed == WT - 1) np = 0;
        default: if (!fl) np = 5;
      endcase
    end
    if (np == 6 && phase != 6) ped = 0;
    else if (phase != 6 && preq) ped = 1;
    elapsed = (np != phase) ? 0 : elapsed + 1;
    phase = np;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    bit   off_half;
    e.main_sig = 2'd0; e.cntry_sig = 2'd0; e.walk = 1'b0;
    e.state = 3'(phase);
    off_half = ((elapsed / FH) % 2) == 1;
    case (phase)
      0: e.main_sig = 2'd2;
      1: e.main_sig = 2'd1;
      3: e.cntry_sig = 2'd2;
      4: e.cntry_sig = 2'd1;
      6: e.walk = 1'b1;
      7: begin
        e.main_sig  = off_half ? 2'd3 : 2'd1;
        e.cntry_sig = off_half ? 2'd3 : 2'd0;
      end
      default: ;
    endcase
    return e;
  endfunction

  task automatic step(input bit clr, input bit car, input bit preq, input bit fl);
    CLEAR = clr; CAR_ON_CNTRY_RD = car; PED_REQ = preq; FLASH_MODE = fl;
    @(posedge CLOCK);
    model_step(clr, car, preq, fl);
    exp_q.push_back(model_out());
    #1;
  endtask

  task automatic idle(input int n, input bit car, input bit fl);
    for (int i = 0; i < n; i++) step(0, car, 0, fl);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLOCK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (MAIN_SIG !== e.main_sig || CNTRY_SIG !== e.cntry_sig ||
            WALK !== e.walk || STATE !== e.state) begin
          errors++;
          $display("FAIL heads t=%0t: got main=%0d cntry=%0d walk=%0b state=%0d, want main=%0d cntry=%0d walk=%0b state=%0d",
                   $time, MAIN_SIG, CNTRY_SIG, WALK, STATE,
                   e.main_sig, e.cntry_sig, e.walk, e.state);
        end
      end
    end
  end

  initial begin : stimulus
    bit car, fl, clr, preq;
    // car held: full cycle with country max cut-off, twice
    repeat (5) step(1, 0, 0, 0);
    idle(60, 1, 0);
    // car absent 20 cycles, then present 7 cycles
    repeat (5) step(1, 0, 0, 0);
    idle(20, 0, 0);
    idle(7, 1, 0);
    idle(12, 0, 0);
    // single pedestrian pulse at cnt=2, no car
    step(1, 0, 0, 0);
    idle(2, 0, 0);
    step(0, 0, 1, 0);
    idle(30, 0, 0);
    // pedestrian and car together; second press during walk
    step(1, 0, 0, 0);
    idle(3, 1, 0);
    step(0, 1, 1, 0);
    idle(16, 1, 0);
    step(0, 1, 1, 0);
    idle(30, 1, 0);
    // flash entered from country green cnt=3, then released
    step(1, 0, 0, 0);
    idle(16, 1, 0);
    idle(20, 1, 1);
    idle(12, 0, 0);
    // clear during country yellow with a pending request, and during flash
    step(1, 0, 0, 0);
    idle(24, 1, 0);
    step(0, 1, 1, 0);
    step(1, 1, 0, 0);
    idle(5, 0, 1);
    step(1, 0, 0, 1);
    idle(20, 0, 0);
    // randomized traffic
    car = 0; fl = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0) car = ~car;
      if ($urandom_range(0, 149) == 0) fl = ~fl;
      preq = ($urandom_range(0, 24) == 0);
      clr  = ($urandom_range(0, 199) == 0);
      step(clr, car, preq, fl);
    end
    stim_done = 1;
  end

  initial begin : finisher
    int budget;
    budget = 0;
    while (!stim_done && budget < 20000) begin
      @(posedge CLOCK);
      budget++;
    end
    if (!stim_done) begin
      errors++;
      $display("FAIL stimulus_timeout: got running, want done");
    end
    repeat (3) @(negedge CLOCK);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d left, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
